// File: rtl/gcm_pkg.sv
`default_nettype none
// gcm_pkg: shared widths, feeder state encoding and word-masking helpers.
package gcm_pkg;

    localparam int BLK_W  = 128;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLLECT  = 3'd1,
        SEND_AAD = 3'd2,
        SEND_TXT = 3'd3,
        LEN      = 3'd4
    } state_t;

    // A word that is not the last of its segment always carries four bytes.
    function automatic logic [2:0] word_bytes(input logic last, input logic [2:0] bytes);
        if (!last || bytes == 3'd0 || bytes > 3'd4)
            return 3'd4;
        return bytes;
    endfunction

    function automatic logic [0:WORD_W-1] mask_word(input logic [0:WORD_W-1] w,
                                                    input logic [2:0] n);
        logic [0:WORD_W-1] m;
        m = w;
        for (int k = 0; k < 4; k++) begin
            if (n <= 3'(k))
                m[8*k +: 8] = 8'd0;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gcm_len_counter.sv
`default_nettype none
// gcm_len_counter: saturating 32-bit byte counter with 64-bit bit-length output.
module gcm_len_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        inc_en,
    input  logic [2:0]  inc,
    output logic [63:0] len_bits
);

    logic [31:0] count;
    logic [32:0] sum;

    assign sum = {1'b0, count} + {30'd0, inc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= 32'd0;
        else if (clear)
            count <= 32'd0;
        else if (inc_en)
            count <= sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    end

    assign len_bits = {29'd0, count, 3'b000};

endmodule
`default_nettype wire

// File: rtl/gcm_block_feeder.sv
`default_nettype none
// gcm_block_feeder: packs 32-bit AAD/text words into zero-padded 128-bit GCM
// blocks and finishes each message with the len(A)||len(C) block.
module gcm_block_feeder
    import gcm_pkg::*;
(
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStart,
    input  logic [0:WORD_W-1] iData,
    input  logic              iData_valid,
    input  logic              iData_type,
    input  logic              iData_last,
    input  logic [2:0]        iData_bytes,
    input  logic              iCore_ready,
    output logic              oData_ready,
    output logic [0:BLK_W-1]  oAad,
    output logic              oAad_valid,
    output logic              oAad_last,
    output logic [0:BLK_W-1]  oBlock,
    output logic              oBlock_valid,
    output logic              oBlock_last,
    output logic              oBusy
);

    state_t            state;
    logic [1:0]        wcnt;
    logic [0:BLK_W-1]  asm_blk;
    logic              blk_last;
    logic              first_word;
    logic              exp_type;
    logic              aad_last_pend;

    logic              type_ok;
    logic              take;
    logic [2:0]        nbytes;
    logic [0:WORD_W-1] lane_word;
    logic [63:0]       len_a_bits;
    logic [63:0]       len_c_bits;

    // Words whose type differs from the open segment are consumed but dropped.
    assign type_ok     = first_word | (iData_type == exp_type);
    assign oData_ready = (state == COLLECT);
    assign take        = oData_ready & iData_valid & type_ok & ~iStart;
    assign nbytes      = word_bytes(iData_last, iData_bytes);
    assign lane_word   = mask_word(iData, nbytes);

    gcm_len_counter u_len_a (
        .clk      (iClk),
        .rst      (iRst),
        .clear    (iStart),
        .inc_en   (take & ~iData_type),
        .inc      (nbytes),
        .len_bits (len_a_bits)
    );

    gcm_len_counter u_len_c (
        .clk      (iClk),
        .rst      (iRst),
        .clear    (iStart),
        .inc_en   (take & iData_type),
        .inc      (nbytes),
        .len_bits (len_c_bits)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state         <= IDLE;
            wcnt          <= 2'd0;
            asm_blk       <= '0;
            blk_last      <= 1'b0;
            first_word    <= 1'b0;
            exp_type      <= 1'b0;
            aad_last_pend <= 1'b0;
            oAad          <= '0;
            oAad_valid    <= 1'b0;
            oAad_last     <= 1'b0;
            oBlock        <= '0;
            oBlock_valid  <= 1'b0;
            oBlock_last   <= 1'b0;
            oBusy         <= 1'b0;
        end else begin
            oAad_valid   <= 1'b0;
            oAad_last    <= 1'b0;
            oBlock_valid <= 1'b0;
            oBlock_last  <= 1'b0;
            if (iStart) begin
                state         <= COLLECT;
                wcnt          <= 2'd0;
                asm_blk       <= '0;
                blk_last      <= 1'b0;
                first_word    <= 1'b1;
                exp_type      <= 1'b0;
                aad_last_pend <= 1'b0;
                oAad          <= '0;
                oBlock        <= '0;
                oBusy         <= 1'b1;
            end else begin
                case (state)
                    COLLECT: begin
                        if (aad_last_pend && iCore_ready) begin
                            oAad_last     <= 1'b1;
                            aad_last_pend <= 1'b0;
                        end
                        if (take) begin
                            asm_blk[{wcnt, 5'd0} +: WORD_W] <= lane_word;
                            wcnt       <= iData_last ? 2'd0 : wcnt + 2'd1;
                            first_word <= 1'b0;
                            exp_type   <= iData_last | iData_type;
                            blk_last   <= iData_last;
                            // Message without AAD still owes the core an AAD-last marker.
                            if (first_word && iData_type)
                                aad_last_pend <= 1'b1;
                            if (wcnt == 2'd3 || iData_last)
                                state <= iData_type ? SEND_TXT : SEND_AAD;
                        end
                    end
                    SEND_AAD: begin
                        if (iCore_ready) begin
                            oAad       <= asm_blk;
                            oAad_valid <= 1'b1;
                            oAad_last  <= blk_last;
                            asm_blk    <= '0;
                            state      <= COLLECT;
                        end
                    end
                    SEND_TXT: begin
                        if (iCore_ready) begin
                            if (aad_last_pend) begin
                                oAad_last     <= 1'b1;
                                aad_last_pend <= 1'b0;
                            end else begin
                                oBlock       <= asm_blk;
                                oBlock_valid <= 1'b1;
                                oBlock_last  <= blk_last;
                                asm_blk      <= '0;
                                state        <= blk_last ? LEN : COLLECT;
                            end
                        end
                    end
                    LEN: begin
                        oAad <= {len_a_bits, len_c_bits};
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gcm_block_feeder.sv
`default_nettype none
// tb_gcm_block_feeder: directed stimulus with a scoreboard of expected block strobes.
module tb_gcm_block_feeder;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  data = '0;
    logic         valid = 1'b0;
    logic         dtype = 1'b0;
    logic         last = 1'b0;
    logic [2:0]   bytes = 3'd4;
    logic         core_ready = 1'b1;
    logic         data_ready;
    logic [0:127] aad;
    logic         aad_valid;
    logic         aad_last;
    logic [0:127] blk;
    logic         blk_valid;
    logic         blk_last;
    logic         busy;

    typedef struct packed {
        logic [1:0]   kind;   // 0 AAD block, 1 standalone AAD-last, 2 text block
        logic         last;
        logic [127:0] data;
    } ev_t;

    ev_t sb[$];
    int  vectors = 0;
    int  errors  = 0;

    gcm_block_feeder dut (
        .iClk         (clk),
        .iRst         (rst),
        .iStart       (start),
        .iData        (data),
        .iData_valid  (valid),
        .iData_type   (dtype),
        .iData_last   (last),
        .iData_bytes  (bytes),
        .iCore_ready  (core_ready),
        .oData_ready  (data_ready),
        .oAad         (aad),
        .oAad_valid   (aad_valid),
        .oAad_last    (aad_last),
        .oBlock       (blk),
        .oBlock_valid (blk_valid),
        .oBlock_last  (blk_last),
        .oBusy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic l, input logic [127:0] d);
        ev_t e;
        e.kind = kind;
        e.last = l;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic check_ev(input logic [1:0] kind, input logic l, input logic [127:0] d);
        ev_t e;
        vectors++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_strobe: observed kind %0d with empty scoreboard, expected no strobe", kind);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("strobe_kind", 128'(kind), 128'(e.kind));
            chk("strobe_last", 128'(l), 128'(e.last));
            if (e.kind != 2'd1)
                chk("strobe_data", d, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (aad_valid || aad_last)
            check_ev(aad_valid ? 2'd0 : 2'd1, aad_last, aad_valid ? aad : 128'd0);
        if (blk_valid)
            check_ev(2'd2, blk_last, blk);
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic t, input logic l, input logic [2:0] b);
        int n;
        n = 0;
        data = d; dtype = t; last = l; bytes = b; valid = 1'b1;
        @(negedge clk);
        while (!data_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 128'(data_ready), 128'd1);
        @(posedge clk);
        #1 valid = 1'b0; last = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    endtask

    task automatic check_len(input logic [63:0] a_bits, input logic [63:0] c_bits);
        repeat (3) @(negedge clk);
        chk("len_block", aad, {a_bits, c_bits});
        chk("len_aad_valid", 128'(aad_valid), 128'd0);
        chk("len_data_ready", 128'(data_ready), 128'd0);
        chk("len_busy", 128'(busy), 128'd1);
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data_ready", 128'(data_ready), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_aad", aad, 128'd0);
        chk("rst_block", blk, 128'd0);
        chk("rst_strobes", 128'({aad_valid, aad_last, blk_valid, blk_last}), 128'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Full AAD block then full text block
        push(2'd0, 1'b1, 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3);
        push(2'd2, 1'b1, 128'h01020304_05060708_090A0B0C_0D0E0F10);
        do_start();
        chk("busy_after_start", 128'(busy), 128'd1);
        send(32'hA0A1A2A3, 1'b0, 1'b0, 3'd4);
        send(32'hB0B1B2B3, 1'b0, 1'b0, 3'd4);
        send(32'hC0C1C2C3, 1'b0, 1'b0, 3'd4);
        send(32'hD0D1D2D3, 1'b0, 1'b1, 3'd4);
        send(32'h01020304, 1'b1, 1'b0, 3'd4);
        send(32'h05060708, 1'b1, 1'b0, 3'd4);
        send(32'h090A0B0C, 1'b1, 1'b0, 3'd4);
        send(32'h0D0E0F10, 1'b1, 1'b1, 3'd4);
        wait_drain();
        check_len(64'd128, 64'd128);

        // No AAD, five text words with a 2-byte tail
        push(2'd1, 1'b1, 128'd0);
        push(2'd2, 1'b0, 128'h10111213_20212223_30313233_40414243);
        push(2'd2, 1'b1, {16'hDEAD, 112'd0});
        do_start();
        send(32'h10111213, 1'b1, 1'b0, 3'd4);
        send(32'h20212223, 1'b1, 1'b0, 3'd4);
        send(32'h30313233, 1'b1, 1'b0, 3'd4);
        send(32'h40414243, 1'b1, 1'b0, 3'd4);
        send(32'hDEADBEEF, 1'b1, 1'b1, 3'd2);
        wait_drain();
        check_len(64'd0, 64'd144);

        // Core stalls while a text block is pending
        push(2'd0, 1'b1, {32'hC1C2C300, 96'd0});
        push(2'd2, 1'b1, {32'h77665544, 32'h33221100, 64'd0});
        do_start();
        send(32'hC1C2C3C4, 1'b0, 1'b1, 3'd3);
        send(32'h77665544, 1'b1, 1'b0, 3'd4);
        core_ready = 1'b0;
        send(32'h33221100, 1'b1, 1'b1, 3'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_no_strobe", 128'(blk_valid), 128'd0);
            chk("stall_not_ready", 128'(data_ready), 128'd0);
        end
        core_ready = 1'b1;
        wait_drain();
        check_len(64'd24, 64'd64);

        // Reset mid-message aborts it; next message counts from zero
        core_ready = 1'b0;
        do_start();
        send(32'hAAAA5555, 1'b1, 1'b0, 3'd4);
        send(32'h5555AAAA, 1'b1, 1'b0, 3'd4);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_data_ready", 128'(data_ready), 128'd0);
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_block", blk, 128'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        core_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_idle", 128'(data_ready), 128'd0);
        push(2'd0, 1'b1, {8'h5A, 120'd0});
        push(2'd2, 1'b1, {8'h11, 120'd0});
        do_start();
        send(32'h5A6B7C8D, 1'b0, 1'b1, 3'd1);
        send(32'h11223344, 1'b1, 1'b1, 3'd1);
        wait_drain();
        check_len(64'd8, 64'd8);

        // Type flip without a closing last word is dropped
        push(2'd0, 1'b1, {32'h0A0B0C0D, 32'h1A1B1C1D, 64'd0});
        push(2'd2, 1'b1, {32'h2A2B2C2D, 96'd0});
        do_start();
        send(32'h0A0B0C0D, 1'b0, 1'b0, 3'd4);
        send(32'hFFFFFFFF, 1'b1, 1'b0, 3'd4);
        send(32'h1A1B1C1D, 1'b0, 1'b1, 3'd4);
        send(32'h2A2B2C2D, 1'b1, 1'b1, 3'd4);
        wait_drain();
        check_len(64'd64, 64'd32);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gcm_block_feeder.md
GCM_BLOCK_FEEDER -- requirements
Module: gcm_block_feeder

Interface
REQ-001 The block SHALL use one clock, iClk, and an asynchronous, active-high reset, iRst.
REQ-002 Parameter: none; block width is fixed at 128 bits and word width at 32 bits.
REQ-003 iClk  in  1  rising-edge clock.
REQ-004 iRst  in  1  asynchronous active-high reset.
REQ-005 iStart  in  1  one-cycle pulse; begins a new message and clears all counters.
REQ-006 iData  in  [0:31]  input word, big-endian; byte 0 is iData[0:7].
REQ-007 iData_valid  in  1  word present; accepted when iData_valid & oData_ready.
REQ-008 iData_type  in  1  0 = AAD word, 1 = text (plain or cipher) word.
REQ-009 iData_last  in  1  marks the last word of the current segment type.
REQ-010 iData_bytes  in  [2:0]  valid bytes in the word, 1..4; only meaningful when iData_last = 1, otherwise treated as 4.
REQ-011 iCore_ready  in  1  downstream GCM core ready (its oReady).
REQ-012 oData_ready  out  1  the feeder can accept a word this cycle.
REQ-013 oAad  out  [0:127]  AAD block; carries the len(A)||len(C) block in state LEN.
REQ-014 oAad_valid, oAad_last  out  1 each  one-cycle AAD block strobe and last-AAD strobe.
REQ-015 oBlock  out  [0:127]  text block, zero-padded.
REQ-016 oBlock_valid, oBlock_last  out  1 each  one-cycle text block strobe and last-text flag (coincident with final strobe).
REQ-017 oBusy  out  1  high from iStart until the LEN state is left.

Function
REQ-018 FSM states SHALL be IDLE, COLLECT, SEND_AAD, SEND_TXT, LEN; the FSM enters COLLECT on iStart from any state.
REQ-019 COLLECT: oData_ready = 1; each accepted word SHALL be written to lane wcnt (0..3) of a 128-bit assembly register, and wcnt SHALL increment modulo 4.
REQ-020 Bytes beyond iData_bytes in a last word, and all unwritten lanes, SHALL be zero in the emitted block.
REQ-021 The FSM SHALL go to SEND_AAD/SEND_TXT (per the type of the captured word) when wcnt wraps 3->0 or iData_last is accepted; oData_ready = 0 outside COLLECT.
REQ-022 SEND_x: the strobe SHALL be raised for exactly one cycle, in the first cycle with iCore_ready = 1; the block SHALL then be cleared and the FSM SHALL return to COLLECT.
REQ-023 oAad_last SHALL accompany the last AAD block; if the first word accepted after iStart is text, a standalone oAad_last pulse (oAad_valid = 0) SHALL be issued when iCore_ready = 1 before any text block.
REQ-024 After the block carrying iData_last with type 1 is sent, the FSM SHALL enter LEN and drive oAad = {lenA_bits[63:0], lenC_bits[63:0]}; it SHALL hold until iStart or reset, with oAad_valid = 0.
REQ-025 Byte counters lenA and lenC are 32 bits each, incremented by the accepted byte count; the bit length is the counter shifted left by 3, zero-extended to 64 bits; counters saturate at 2^32-1.
REQ-026 A type change without a preceding iData_last SHALL be ignored: the word is dropped and the counters are not updated.
REQ-027 Latency: last word accepted -> block strobe is at least 1 cycle and equals 1 when iCore_ready = 1.

Reset
REQ-028 During iRst the block SHALL hold: state IDLE, oData_ready = 0, all strobes 0, oBusy = 0, oAad/oBlock = 0, counters = 0, wcnt = 0.
REQ-029 Reset asserted mid-message SHALL abort the message with no further strobes.

Structure
REQ-030 FSM state encodings and width constants (BLK_W = 128, WORD_W = 32) SHALL live in the shared package gcm_pkg.
REQ-031 A single sub-module, gcm_len_counter (saturating byte counter plus bit-length formatter), SHALL be instantiated twice, once for lenA and once for lenC.

Verification
REQ-032 4 AAD words + iData_last (bytes = 4), 4 text words, last -> one oAad_valid with oAad_last, one oBlock_valid with oBlock_last, LEN oAad = 0x...0080_..._0080.
REQ-033 No AAD; 5 text words, last iData_bytes = 2 -> standalone oAad_last; second block = word4[0:15] followed by 112 zero bits; lenC_bits = 144.
REQ-034 iCore_ready held low for 10 cycles during SEND_TXT -> a single strobe on the first ready cycle; oData_ready = 0 throughout.
REQ-035 iRst pulsed after 2 text words -> no strobes; next iStart yields fresh counts starting from 0.
REQ-036 Type flip AAD -> text without iData_last -> word dropped; lenC unchanged.
